// File: rtl/uart_mmio_bridge.sv
// MMIO slave bridging the CPU data port to a UART ready/valid pair: RX FIFO, TX holding
// register, sticky drop status and optional perf counters (enabled by UART_MMIO_COUNTERS_EN).
module uart_mmio_bridge #(
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_en,
    input  logic        re,
    input  logic [3:0]  wea,
    input  logic [4:0]  adr,
    input  logic [31:0] wdata,
    input  logic        instr_valid,
    output logic [31:0] dout,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam int AW = $clog2(RX_FIFO_DEPTH);

    logic [31:0] r_dout;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_tx_drop;
    logic [7:0]  r_mem [RX_FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [31:0] w_rdata;
    logic        w_load;
    logic        w_store;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_tx_store;
    logic        w_status_load;
    logic        w_unused_wdata;

    assign w_load         = io_en & re;
    assign w_store        = io_en & (|wea);
    assign w_empty        = (r_wptr == r_rptr);
    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_full         = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push         = uart_rx_valid & ~w_full;
    assign w_pop          = w_load & (adr == 5'd1) & ~w_empty;
    assign w_tx_store     = w_store & (adr == 5'd2);
    assign w_status_load  = w_load & (adr == 5'd0);
    assign w_unused_wdata = ^wdata[31:8];

    assign dout          = r_dout;
    assign uart_tx_data  = r_tx_data;
    assign uart_tx_valid = r_tx_valid;
    assign uart_rx_ready = ~w_full;

`ifdef UART_MMIO_COUNTERS_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_ins_cnt;
    logic        w_cnt_clr;

    assign w_cnt_clr = w_store & (adr == 5'd6);

    // Performance counters; a clear store wins over the increment of the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt <= 32'd0;
            r_ins_cnt <= 32'd0;
        end else if (w_cnt_clr) begin
            r_cyc_cnt <= 32'd0;
            r_ins_cnt <= 32'd0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (instr_valid) begin
                r_ins_cnt <= r_ins_cnt + 32'd1;
            end
        end
    end
`else
    logic w_unused_instr;
    assign w_unused_instr = instr_valid;
`endif

    // Read data mux, evaluated against pre-edge state.
    always_comb begin
        w_rdata = 32'd0;
        case (adr)
            5'd0:    w_rdata = {29'd0, r_tx_drop, ~w_empty, ~r_tx_valid};
            5'd1:    w_rdata = w_empty ? 32'd0 : {24'd0, r_mem[r_rptr[AW-1:0]]};
`ifdef UART_MMIO_COUNTERS_EN
            5'd4:    w_rdata = r_cyc_cnt;
            5'd5:    w_rdata = r_ins_cnt;
`endif
            default: w_rdata = 32'd0;
        endcase
    end

    // Registered load data, held between loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= 32'd0;
        end else if (w_load) begin
            r_dout <= w_rdata;
        end
    end

    // RX FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // RX FIFO storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= uart_rx_data;
        end
    end

    // TX holding register and sticky drop flag; a store seen while busy is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
            r_tx_drop  <= 1'b0;
        end else begin
            r_tx_drop <= (w_tx_store & r_tx_valid) | (r_tx_drop & ~w_status_load);
            if (w_tx_store && !r_tx_valid) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= wdata[7:0];
            end else if (r_tx_valid && uart_tx_ready) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed self-checking bench for uart_mmio_bridge: table-driven TX/register vectors plus
// hand-written reset, RX FIFO and counter sequences.
module tb_uart_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_en;
    logic        re;
    logic [3:0]  wea;
    logic [4:0]  adr;
    logic [31:0] wdata;
    logic        instr_valid;
    logic [31:0] dout;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    int checks   = 0;
    int failures = 0;

    uart_mmio_bridge #(.RX_FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .io_en(io_en), .re(re), .wea(wea), .adr(adr), .wdata(wdata),
        .instr_valid(instr_valid), .dout(dout), .uart_tx_data(uart_tx_data),
        .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        io_en;
        logic        re;
        logic [3:0]  wea;
        logic [4:0]  adr;
        logic [31:0] wdata;
        logic        tx_ready;
        logic        chk_dout;
        logic [31:0] exp_dout;
        logic        exp_txv;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one bus cycle starting at a negedge; returns at the next negedge.
    task automatic step(input logic en, input logic r, input logic [3:0] we,
                        input logic [4:0] a, input logic [31:0] wd);
        io_en = en; re = r; wea = we; adr = a; wdata = wd;
        @(negedge clk);
        io_en = 1'b0; re = 1'b0; wea = 4'h0; adr = 5'd0; wdata = 32'd0;
    endtask

    task automatic load(input logic [4:0] a);
        step(1'b1, 1'b1, 4'h0, a, 32'd0);
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1; io_en = 1'b0; re = 1'b0; wea = 4'h0; adr = 5'd0; wdata = 32'd0;
        instr_valid = 1'b0; uart_tx_ready = 1'b0; uart_rx_data = 8'd0; uart_rx_valid = 1'b0;

        //             en    re    wea   adr    wdata          txr   chk   exp_dout txv   txd
        vecs[0]  = '{1'b1, 1'b0, 4'hF, 5'd2, 32'h0000_0041, 1'b0, 1'b0, 32'd0, 1'b1, 8'h41};
        vecs[1]  = '{1'b0, 1'b0, 4'h0, 5'd0, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 1'b1, 8'h41};
        vecs[2]  = '{1'b1, 1'b0, 4'h1, 5'd2, 32'h0000_0042, 1'b0, 1'b0, 32'd0, 1'b1, 8'h41};
        vecs[3]  = '{1'b0, 1'b0, 4'h0, 5'd0, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 1'b1, 8'h41};
        vecs[4]  = '{1'b1, 1'b1, 4'h0, 5'd0, 32'h0000_0000, 1'b0, 1'b1, 32'd4, 1'b1, 8'h41};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 5'd0, 32'h0000_0000, 1'b1, 1'b1, 32'd4, 1'b0, 8'h41};
        vecs[6]  = '{1'b1, 1'b1, 4'h0, 5'd0, 32'h0000_0000, 1'b0, 1'b1, 32'd1, 1'b0, 8'h41};
        vecs[7]  = '{1'b1, 1'b0, 4'hF, 5'd2, 32'h0000_0043, 1'b0, 1'b0, 32'd0, 1'b1, 8'h43};
        vecs[8]  = '{1'b1, 1'b0, 4'hF, 5'd2, 32'h0000_0044, 1'b1, 1'b0, 32'd0, 1'b0, 8'h43};
        vecs[9]  = '{1'b1, 1'b1, 4'h0, 5'd0, 32'h0000_0000, 1'b0, 1'b1, 32'd5, 1'b0, 8'h43};
        vecs[10] = '{1'b1, 1'b1, 4'h0, 5'd0, 32'h0000_0000, 1'b0, 1'b1, 32'd1, 1'b0, 8'h43};
        vecs[11] = '{1'b0, 1'b1, 4'h0, 5'd3, 32'h0000_0000, 1'b0, 1'b1, 32'd1, 1'b0, 8'h43};
        vecs[12] = '{1'b1, 1'b1, 4'h0, 5'd3, 32'h0000_0000, 1'b0, 1'b1, 32'd0, 1'b0, 8'h43};
        vecs[13] = '{1'b0, 1'b0, 4'hF, 5'd2, 32'h0000_0055, 1'b0, 1'b1, 32'd0, 1'b0, 8'h43};
        vecs[14] = '{1'b1, 1'b0, 4'hF, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 1'b0, 8'h43};
        vecs[15] = '{1'b1, 1'b1, 4'h0, 5'd0, 32'h0000_0000, 1'b0, 1'b1, 32'd1, 1'b0, 8'h43};

        // Reset values, then asynchronous reset in the middle of a TX handshake.
        repeat (2) @(negedge clk);
        check("rst_dout", dout, 32'd0);
        check("rst_txv", {31'd0, uart_tx_valid}, 32'd0);
        check("rst_rxr", {31'd0, uart_rx_ready}, 32'd1);
        rst = 1'b0;
        load(5'd0);
        check("status_after_rst", dout, 32'd1);
        step(1'b1, 1'b0, 4'hF, 5'd2, 32'h0000_0041);
        check("tx_pending", {31'd0, uart_tx_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_txv", {31'd0, uart_tx_valid}, 32'd0);
        check("async_rst_txd", {24'd0, uart_tx_data}, 32'd0);
        check("async_rst_dout", dout, 32'd0);
        check("async_rst_rxr", {31'd0, uart_rx_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        load(5'd0);
        check("status_post_rst", dout, 32'd1);

        // TX handshake and register-map vectors.
        for (int i = 0; i < 16; i++) begin
            uart_tx_ready = vecs[i].tx_ready;
            step(vecs[i].io_en, vecs[i].re, vecs[i].wea, vecs[i].adr, vecs[i].wdata);
            uart_tx_ready = 1'b0;
            check($sformatf("vec%0d_txv", i), {31'd0, uart_tx_valid}, {31'd0, vecs[i].exp_txv});
            check($sformatf("vec%0d_txd", i), {24'd0, uart_tx_data}, {24'd0, vecs[i].exp_txd});
            if (vecs[i].chk_dout) begin
                check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            end
        end

        // RX fill to full, hold an extra byte while full, then drain.
        for (int i = 0; i < 8; i++) begin
            b = 8'h10 + 8'(i);
            uart_rx_valid = 1'b1; uart_rx_data = b;
            idle();
            check($sformatf("fill%0d_rxr", i), {31'd0, uart_rx_ready}, (i == 7) ? 32'd0 : 32'd1);
        end
        uart_rx_data = 8'hEE;
        idle();
        check("full_hold_rxr", {31'd0, uart_rx_ready}, 32'd0);
        uart_rx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            load(5'd1);
            check($sformatf("drain%0d", i), dout, 32'h10 + 32'(i));
            check($sformatf("drain%0d_rxr", i), {31'd0, uart_rx_ready}, 32'd1);
        end
        load(5'd1);
        check("drain_empty", dout, 32'd0);
        load(5'd0);
        check("status_empty", dout, 32'd1);

        // Byte pushed at one edge is readable by the very next load.
        uart_rx_valid = 1'b1; uart_rx_data = 8'h77;
        idle();
        uart_rx_valid = 1'b0;
        load(5'd0);
        check("status_rx_valid", dout, 32'd3);
        load(5'd1);
        check("push_then_load", dout, 32'h77);

        // Simultaneous push and pop with three entries queued.
        for (int i = 0; i < 3; i++) begin
            uart_rx_valid = 1'b1; uart_rx_data = 8'h30 + 8'(i);
            idle();
        end
        uart_rx_data = 8'h33;
        load(5'd1);
        check("pp0", dout, 32'h30);
        uart_rx_data = 8'h34;
        load(5'd1);
        check("pp1", dout, 32'h31);
        uart_rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load(5'd1);
            check($sformatf("pp_drain%0d", i), dout, 32'h32 + 32'(i));
        end
        load(5'd1);
        check("pp_empty", dout, 32'd0);

`ifdef UART_MMIO_COUNTERS_EN
        step(1'b1, 1'b0, 4'h8, 5'd6, 32'd0);
        for (int i = 0; i < 100; i++) begin
            instr_valid = (i < 40);
            idle();
        end
        instr_valid = 1'b0;
        load(5'd5);
        check("instr_cnt", dout, 32'd40);
        load(5'd4);
        check("cycle_cnt", dout, 32'd101);
        step(1'b1, 1'b0, 4'h1, 5'd6, 32'd0);
        idle();
        load(5'd4);
        check("cnt_clear", dout, 32'd1);
        force dut.r_cyc_cnt = 32'hFFFF_FFFE;
        force dut.r_ins_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_cyc_cnt;
        release dut.r_ins_cnt;
        instr_valid = 1'b1;
        idle();
        instr_valid = 1'b0;
        load(5'd5);
        check("instr_wrap", dout, 32'd0);
        load(5'd4);
        check("cycle_wrap", dout, 32'd0);
`else
        instr_valid = 1'b1;
        repeat (50) idle();
        instr_valid = 1'b0;
        load(5'd0);
        check("nocnt_status", dout, 32'd1);
        load(5'd4);
        check("nocnt_cycle", dout, 32'd0);
        load(5'd0);
        load(5'd5);
        check("nocnt_instr", dout, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
